// File: rtl/nf1g_input_arbiter.sv
// Packet round-robin merge of four AXI4-Stream ingress ports; define NF1G_ARB_STRICT_PRIO_EN for fixed priority (port 0 highest).
// Latency: 0-cycle combinational data path while granted; one idle arbitration cycle precedes every packet.
// Backpressure: m_axis_tready is forwarded only to the granted port; all other ports see tready low.
module nf1g_input_arbiter #(
    parameter int C_DATA_WIDTH  = 64,
    parameter int C_TUSER_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [C_DATA_WIDTH-1:0]     s_axis_0_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_0_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]    s_axis_0_tuser,
    input  logic                        s_axis_0_tvalid,
    input  logic                        s_axis_0_tlast,
    output logic                        s_axis_0_tready,

    input  logic [C_DATA_WIDTH-1:0]     s_axis_1_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_1_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]    s_axis_1_tuser,
    input  logic                        s_axis_1_tvalid,
    input  logic                        s_axis_1_tlast,
    output logic                        s_axis_1_tready,

    input  logic [C_DATA_WIDTH-1:0]     s_axis_2_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_2_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]    s_axis_2_tuser,
    input  logic                        s_axis_2_tvalid,
    input  logic                        s_axis_2_tlast,
    output logic                        s_axis_2_tready,

    input  logic [C_DATA_WIDTH-1:0]     s_axis_3_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_3_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]    s_axis_3_tuser,
    input  logic                        s_axis_3_tvalid,
    input  logic                        s_axis_3_tlast,
    output logic                        s_axis_3_tready,

    output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,

    output logic [3:0]                  arb_grant,
    output logic                        arb_busy
);

    typedef struct packed {
        logic [C_DATA_WIDTH-1:0]   tdata;
        logic [C_DATA_WIDTH/8-1:0] tkeep;
        logic [C_TUSER_WIDTH-1:0]  tuser;
        logic                      tlast;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    beat_t      in_beat [4];
    beat_t      out_beat;
    logic [3:0] in_vld;
    logic [3:0] in_rdy;

    state_t     state, state_nxt;
    logic [1:0] grant_idx, grant_idx_nxt;
    logic [1:0] last_idx, last_idx_nxt;
    logic [1:0] pick_idx;
    logic       pick_vld;

    assign in_beat[0] = {s_axis_0_tdata, s_axis_0_tkeep, s_axis_0_tuser, s_axis_0_tlast};
    assign in_beat[1] = {s_axis_1_tdata, s_axis_1_tkeep, s_axis_1_tuser, s_axis_1_tlast};
    assign in_beat[2] = {s_axis_2_tdata, s_axis_2_tkeep, s_axis_2_tuser, s_axis_2_tlast};
    assign in_beat[3] = {s_axis_3_tdata, s_axis_3_tkeep, s_axis_3_tuser, s_axis_3_tlast};
    assign in_vld     = {s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_beat;
    assign s_axis_0_tready = in_rdy[0];
    assign s_axis_1_tready = in_rdy[1];
    assign s_axis_2_tready = in_rdy[2];
    assign s_axis_3_tready = in_rdy[3];

`ifdef NF1G_ARB_STRICT_PRIO_EN
    always_comb begin
        pick_vld = |in_vld;
        pick_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (in_vld[i]) pick_idx = 2'(i);
        end
    end
`else
    logic [1:0] cand_idx;

    // Walk from lowest to highest priority so the port just after last_idx wins.
    always_comb begin
        pick_vld = |in_vld;
        pick_idx = '0;
        cand_idx = '0;
        for (int i = 4; i >= 1; i--) begin
            cand_idx = last_idx + 2'(i);
            if (in_vld[cand_idx]) pick_idx = cand_idx;
        end
    end
`endif

    always_comb begin
        out_beat      = '0;
        m_axis_tvalid = 1'b0;
        in_rdy        = '0;
        arb_grant     = '0;
        arb_busy      = 1'b0;
        if (state == PKT) begin
            out_beat            = in_beat[grant_idx];
            m_axis_tvalid       = in_vld[grant_idx];
            in_rdy[grant_idx]   = m_axis_tready;
            arb_grant[grant_idx] = 1'b1;
            arb_busy            = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_idx_nxt = grant_idx;
        last_idx_nxt  = last_idx;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_idx_nxt = pick_idx;
                    state_nxt     = PKT;
                end
            end
            PKT: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    last_idx_nxt = grant_idx;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_idx resets to 3 so the first search starts at port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= 2'd0;
            last_idx  <= 2'd3;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_idx_nxt;
            last_idx  <= last_idx_nxt;
        end
    end

endmodule

// File: tb/tb_nf1g_input_arbiter.sv
// Scoreboard bench for nf1g_input_arbiter: randomized packet sources, packet-level reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_nf1g_input_arbiter;
    localparam int DW = 64;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            port;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_dat  [4];
    logic [KW-1:0] s_keep [4];
    logic [UW-1:0] s_user [4];
    logic [3:0]    s_vld = '0;
    logic [3:0]    s_last = '0;
    wire  [3:0]    s_rdy;
    wire  [DW-1:0] m_dat;
    wire  [KW-1:0] m_keep;
    wire  [UW-1:0] m_user;
    wire           m_last, m_vld;
    logic          m_rdy = 1'b1;
    wire  [3:0]    arb_grant;
    wire           arb_busy;

    int    checks = 0;
    int    errors = 0;
    beat_t src_q [4][$];
    beat_t exp_q [$];
    int    egress [$];
    logic [3:0] hs = '0;
    logic  rst_s = 1'b0;
    int    bubble_pct = 0;
    int    rdy_mode = 0;
    logic  rdy_fixed = 1'b1;
    bit    mdl_busy = 1'b0;
    int    mdl_port = 0;
    int    mdl_last = 3;
    bit    stall_prev = 1'b0;
    logic [DW-1:0] stall_d;
    logic  stall_l;

    always #5 clk = ~clk;

    nf1g_input_arbiter #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW)) dut (
        .clk(clk), .reset(reset),
        .s_axis_0_tdata(s_dat[0]), .s_axis_0_tkeep(s_keep[0]), .s_axis_0_tuser(s_user[0]),
        .s_axis_0_tvalid(s_vld[0]), .s_axis_0_tlast(s_last[0]), .s_axis_0_tready(s_rdy[0]),
        .s_axis_1_tdata(s_dat[1]), .s_axis_1_tkeep(s_keep[1]), .s_axis_1_tuser(s_user[1]),
        .s_axis_1_tvalid(s_vld[1]), .s_axis_1_tlast(s_last[1]), .s_axis_1_tready(s_rdy[1]),
        .s_axis_2_tdata(s_dat[2]), .s_axis_2_tkeep(s_keep[2]), .s_axis_2_tuser(s_user[2]),
        .s_axis_2_tvalid(s_vld[2]), .s_axis_2_tlast(s_last[2]), .s_axis_2_tready(s_rdy[2]),
        .s_axis_3_tdata(s_dat[3]), .s_axis_3_tkeep(s_keep[3]), .s_axis_3_tuser(s_user[3]),
        .s_axis_3_tvalid(s_vld[3]), .s_axis_3_tlast(s_last[3]), .s_axis_3_tready(s_rdy[3]),
        .m_axis_tdata(m_dat), .m_axis_tkeep(m_keep), .m_axis_tuser(m_user),
        .m_axis_tlast(m_last), .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy),
        .arb_grant(arb_grant), .arb_busy(arb_busy)
    );

    // Arbitration rule: next requester after the previous winner, or lowest index in strict mode.
    function automatic int pick(logic [3:0] v, int last);
`ifdef NF1G_ARB_STRICT_PRIO_EN
        for (int k = 0; k < 4; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g == (4'b0001 << k)) return k;
        return -1;
    endfunction

    // Reference model: per-cycle control expectations and packet-level grant decisions.
    always @(negedge clk) begin : model
        logic [9:0] exp_ctl;
        logic [9:0] act_ctl;
        exp_ctl = '0;
        if (mdl_busy) begin
            exp_ctl[9:6] = 4'b0001 << mdl_port;
            exp_ctl[5]   = 1'b1;
            exp_ctl[4]   = s_vld[mdl_port];
            exp_ctl[3:0] = m_rdy ? (4'b0001 << mdl_port) : 4'b0000;
        end
        act_ctl = {arb_grant, arb_busy, m_vld, s_rdy};
        checks++;
        if (act_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL ctl t=%0t grant,busy,valid,readys got %b required %b", $time, act_ctl, exp_ctl);
        end
        hs    = s_rdy & s_vld;
        rst_s = reset;
        if (reset) begin
            mdl_busy = 1'b0;
            mdl_last = 3;
            exp_q.delete();
        end else if (!mdl_busy) begin
            if (s_vld != 4'b0000) begin
                mdl_port = pick(s_vld, mdl_last);
                mdl_busy = 1'b1;
                for (int i = 0; i < src_q[mdl_port].size(); i++) begin
                    exp_q.push_back(src_q[mdl_port][i]);
                    if (src_q[mdl_port][i].l) break;
                end
            end
        end else if (s_vld[mdl_port] && m_rdy && src_q[mdl_port][0].l) begin
            mdl_last = mdl_port;
            mdl_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        beat_t e;
        int    gi;
        if (stall_prev) begin
            checks++;
            if (!m_vld || m_dat !== stall_d || m_last !== stall_l) begin
                errors++;
                $display("FAIL stall_hold t=%0t got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         $time, m_vld, m_dat, m_last, stall_d, stall_l);
            end
        end
        stall_prev = m_vld && !m_rdy && !reset;
        stall_d    = m_dat;
        stall_l    = m_last;
        if (m_vld && m_rdy) begin
            checks++;
            gi = onehot_idx(arb_grant);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat t=%0t unexpected beat d=%h from grant %b, none required", $time, m_dat, arb_grant);
            end else begin
                e = exp_q.pop_front();
                if (m_dat !== e.d || m_keep !== e.k || m_user !== e.u || m_last !== e.l || gi != e.port) begin
                    errors++;
                    $display("FAIL beat t=%0t got port=%0d d=%h k=%h l=%b required port=%0d d=%h k=%h l=%b",
                             $time, gi, m_dat, m_keep, m_last, e.port, e.d, e.k, e.l);
                end
                if (m_last) egress.push_back(gi);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (rst_s) begin
                src_q[p].delete();
                s_vld[p] = 1'b0;
            end else begin
                if (hs[p]) begin
                    void'(src_q[p].pop_front());
                    s_vld[p] = 1'b0;
                end
                if (!s_vld[p] && src_q[p].size() > 0 && $urandom_range(99) >= bubble_pct)
                    s_vld[p] = 1'b1;
            end
            if (src_q[p].size() > 0) begin
                s_dat[p]  = src_q[p][0].d;
                s_keep[p] = src_q[p][0].k;
                s_user[p] = src_q[p][0].u;
                s_last[p] = src_q[p][0].l;
            end else begin
                s_dat[p]  = '0;
                s_keep[p] = '0;
                s_user[p] = '0;
                s_last[p] = 1'b0;
            end
        end
        case (rdy_mode)
            1:       m_rdy = ($urandom_range(3) != 0);
            2:       m_rdy = ~m_rdy;
            default: m_rdy = rdy_fixed;
        endcase
    endtask

    task automatic push_pkt(int p, int len, bit seq, logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d    = seq ? base + DW'(i) : {$urandom, $urandom};
            b.k    = (i == len - 1 && !seq) ? KW'($urandom_range(255, 1)) : '1;
            b.u    = {$urandom, $urandom, $urandom, $urandom};
            b.l    = (i == len - 1);
            b.port = p;
            src_q[p].push_back(b);
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < 4; p++) if (src_q[p].size() > 0) return 1'b1;
        return (exp_q.size() > 0) || mdl_busy;
    endfunction

    task automatic drain(string name, int bound);
        int n = 0;
        while (pending() && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL %s drain timeout after %0d cycles, required traffic to complete", name, n);
        end
    endtask

    task automatic check_order(string name, int want[$]);
        checks++;
        if (egress.size() != want.size()) begin
            errors++;
            $display("FAIL %s packet count got %0d required %0d", name, egress.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                checks++;
                if (egress[i] != want[i]) begin
                    errors++;
                    $display("FAIL %s packet %0d egress port got %0d required %0d", name, i, egress[i], want[i]);
                end
            end
        end
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w[$];
        for (int p = 0; p < 4; p++) begin
            s_dat[p] = '0; s_keep[p] = '0; s_user[p] = '0;
        end
        do_reset(50);

        // Port 2 alone, 4 sequential beats.
        push_pkt(2, 4, 1'b1, 64'h1);
        egress.delete();
        drain("single_port", 200);
        w.delete(); w.push_back(2);
        check_order("single_port", w);

        // All ports, three 2-beat packets each, after reset.
        do_reset(2);
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 4; p++) push_pkt(p, 2, 1'b0, '0);
        egress.delete();
        drain("all_ports", 500);
        w.delete();
        for (int i = 0; i < 12; i++) begin
`ifdef NF1G_ARB_STRICT_PRIO_EN
            w.push_back(i / 3);
`else
            w.push_back(i % 4);
`endif
        end
        check_order("all_ports", w);

        // Toggling backpressure on port 1 with port 0 waiting.
        rdy_mode = 2;
        egress.delete();
        push_pkt(1, 3, 1'b1, 64'h100);
        step();
        push_pkt(0, 2, 1'b1, 64'h200);
        drain("backpressure", 200);
        w.delete(); w.push_back(1); w.push_back(0);
        check_order("backpressure", w);

        // Reset on beat 2 of a 5-beat packet from port 3.
        rdy_mode = 0;
        rdy_fixed = 1'b1;
        push_pkt(3, 5, 1'b1, 64'h300);
        step();
        step();
        step();
        reset = 1'b1;
        rdy_fixed = 1'b0;
        m_rdy = 1'b0;
        step();
        step();
        reset = 1'b0;
        rdy_fixed = 1'b1;
        step();
        egress.delete();
        push_pkt(2, 2, 1'b1, 64'h400);
        push_pkt(0, 2, 1'b1, 64'h500);
        drain("reset_mid_pkt", 200);
        w.delete(); w.push_back(0); w.push_back(2);
        check_order("reset_mid_pkt", w);

        // Simultaneous single-beat packets from ports 1 and 3.
        do_reset(3);
        egress.delete();
        push_pkt(1, 1, 1'b1, 64'h600);
        push_pkt(3, 1, 1'b1, 64'h700);
        drain("single_beat", 100);
        w.delete(); w.push_back(1); w.push_back(3);
        check_order("single_beat", w);

        // Random traffic, bubbles and backpressure.
        bubble_pct = 30;
        rdy_mode = 1;
        for (int r = 0; r < 60; r++) begin
            for (int j = 0; j < 5; j++)
                push_pkt($urandom_range(3), $urandom_range(6, 1), 1'b0, '0);
            repeat ($urandom_range(10)) step();
        end
        drain("random", 20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
